// File: rtl/seq_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_mul_pkg
// Description : Shared types and constants for the sequential shift-and-add
//               multiplier: FSM state encoding, default operand width and
//               the iteration-counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_mul_pkg;

  // Default operand width; product and accumulator are twice this
  localparam int unsigned SEQ_MUL_WIDTH_DEF = 8;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } seq_mul_state_e;

  // Iteration counter width: one extra bit over the index range keeps
  // the counter from aliasing when WIDTH is a power of two
  function automatic int unsigned seq_mul_cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_accumulate.sv
`default_nettype none
// ============================================================================
// Module      : mul_accumulate
// Description : 2*WIDTH-bit accumulator register with a conditional adder.
//               'clear' zeroes the register, 'add_en' adds 'mcand' into it.
//               The carry out of the add is dropped: an unsigned WIDTH x WIDTH
//               product always fits in 2*WIDTH bits.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_accumulate
  import seq_mul_pkg::*;
#(
  parameter int unsigned WIDTH = SEQ_MUL_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               add_en,
  input  logic [2*WIDTH-1:0] mcand,
  output logic [2*WIDTH-1:0] acc
);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_sum;

  // Plain 2*WIDTH-bit add, carry-in 0, carry-out discarded
  assign w_sum = r_acc + mcand;

  // Accumulator: clear has priority over a pending add
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (clear) begin
      r_acc <= '0;
    end else if (add_en) begin
      r_acc <= w_sum;
    end
  end

  assign acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/seq_shift_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_shift_add_multiplier
// Description : Unsigned sequential shift-and-add multiplier with valid/ready
//               handshakes on both sides. One multiplier bit is retired per
//               CALC cycle; the result is held in DONE until consumed.
//               Optional build macro SEQ_MUL_EARLY_TERM_EN: leave CALC as
//               soon as the remaining multiplier bits are all zero.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_shift_add_multiplier
  import seq_mul_pkg::*;
#(
  parameter int unsigned WIDTH = SEQ_MUL_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int unsigned           C_CNT_W = seq_mul_cnt_width(WIDTH);
  localparam logic [C_CNT_W-1:0]    C_LAST  = C_CNT_W'(WIDTH - 1);
  localparam logic [C_CNT_W-1:0]    C_ONE   = C_CNT_W'(1);

  seq_mul_state_e       r_state;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [C_CNT_W-1:0]   r_count;

  logic                 w_accept;
  logic                 w_add_en;
  logic [WIDTH-1:0]     w_mplier_next;
  logic                 w_last;
  logic [2*WIDTH-1:0]   w_acc;

  assign w_accept      = in_valid && (r_state == ST_IDLE);
  assign w_add_en      = (r_state == ST_CALC) && r_mplier[0];
  assign w_mplier_next = r_mplier >> 1;

`ifdef SEQ_MUL_EARLY_TERM_EN
  // Stop once no set multiplier bits remain; further adds would be zero
  assign w_last = (r_count == C_LAST) || (w_mplier_next == '0);
`else
  // Fixed latency: always retire all WIDTH multiplier bits
  assign w_last = (r_count == C_LAST);
`endif

  // Controller FSM with the multiplicand/multiplier shift registers and counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_count  <= '0;
            r_state  <= ST_CALC;
          end
        end
        ST_CALC: begin
          // Bits shifted out of the top of mcand are simply lost
          r_mcand  <= r_mcand << 1;
          r_mplier <= w_mplier_next;
          r_count  <= r_count + C_ONE;
          if (w_last) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  mul_accumulate #(
    .WIDTH (WIDTH)
  ) u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (w_accept),
    .add_en (w_add_en),
    .mcand  (r_mcand),
    .acc    (w_acc)
  );

  // Handshake and status outputs decode only the state register
  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state == ST_CALC) || (r_state == ST_DONE);
  assign product   = w_acc;

endmodule
`default_nettype wire
